instr_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline: owns the program counter, drives the word address of the 64-word combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. It is the initiator and reader on the ROM's addr/dout interface. It accepts load-use stalls from the hazard unit and PC redirects from EX (branch, jal, jalr), inserting bubbles on redirect.

---
 rtl/instr_fetch_unit_pkg.sv | 32 +++
 rtl/instr_fetch_unit_pc_reg.sv | 32 +++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared IF-stage definitions: reset PC, bubble encoding, ROM geometry and the IF/ID record.
// Optional range checking in the fetch unit is enabled by defining IFU_RANGE_CHECK_EN.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ROM_AW   = 6;
  localparam logic [31:0] BUBBLE   = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } if_id_t;

  typedef enum logic {
    ST_RESET,
    ST_RUN
  } ifu_state_t;

  // Per-cycle behaviour while running: redirect beats stall beats fetch.
  typedef enum logic [1:0] {
    OP_FETCH,
    OP_HOLD,
    OP_FLUSH
  } ifu_op_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with next-PC selection: reset, redirect target, hold on stall, else +4.
module instr_fetch_unit_pc_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic        stall,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc + 32'd4;
    if (redirect) begin
      pc_next = align_word(target);
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: drives the combinational ROM and fills the IF/ID register.
// Define IFU_RANGE_CHECK_EN to flag out-of-window fetches and misaligned redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       pc,
  output logic              if_id_valid,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  // Handshake: none. rom_data must be valid in the same cycle rom_addr is driven;
  // stall and redirect_valid are level inputs sampled at each rising edge.

  ifu_state_t state, state_next;
  ifu_op_t    op;
  if_id_t     if_id;
  logic       out_of_window;
  logic       misaligned;

  instr_fetch_unit_pc_reg u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .redirect (redirect_valid),
    .stall    (stall),
    .target   (redirect_pc),
    .pc       (pc)
  );

  assign rom_addr = pc[ROM_AW+1:2];

`ifdef IFU_RANGE_CHECK_EN
  assign out_of_window = |pc[31:ROM_AW+2];
  assign misaligned    = |redirect_pc[1:0];
`else
  assign out_of_window = 1'b0;
  assign misaligned    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_RESET) begin
      state_next = ST_RUN;
    end
  end

  // The first edge out of reset already fetches, so both states share the same op select.
  always_comb begin
    op = OP_FETCH;
    if (redirect_valid) begin
      op = OP_FLUSH;
    end else if (stall) begin
      op = OP_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id       <= '{valid: 1'b0, pc: 32'h0, instr: BUBBLE, fault: 1'b0};
      fetch_count <= 32'h0;
    end else begin
      case (op)
        OP_FLUSH: if_id <= '{valid: 1'b0, pc: 32'h0, instr: BUBBLE, fault: misaligned};
        OP_FETCH: begin
          if_id       <= '{valid: 1'b1, pc: pc,
                           instr: (out_of_window ? BUBBLE : rom_data),
                           fault: out_of_window};
          fetch_count <= fetch_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.instr;
  assign fetch_fault = if_id.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by random stall/redirect/reset traffic.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] rom_mem [64];

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef IFU_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // reference model state
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("rom_addr", {26'h0, rom_addr}, (m_pc / 4) % 64);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // Apply one edge of stimulus, advance the model by the same edge, then compare.
  task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    logic oor;
    rst_n          = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    if (!r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = 32'h0; m_fault = 1'b0; m_cnt = 32'h0;
    end else if (rv) begin
      m_pc    = rp - (rp % 4);
      m_valid = 1'b0;
      m_ipc   = 32'h0;
      m_instr = 32'h0;
      m_fault = RC && (rp % 4 != 0);
    end else if (!s) begin
      oor     = RC && (m_pc >= 32'd256);
      m_ipc   = m_pc;
      m_instr = oor ? 32'h0 : rom_mem[(m_pc / 4) % 64];
      m_valid = 1'b1;
      m_fault = oor;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] rp;
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h0000_3F37;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // reset and first fetch
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_valid", {31'h0, if_id_valid}, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_instr", if_id_instr, 32'h0000_3F37);
    chk("first_pc", pc, 32'h4);
    chk("first_count", fetch_count, 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // redirect at pc=8 to 0x20
    cycle(1'b1, 1'b0, 1'b1, 32'h20);
    chk("redir_pc", pc, 32'h20);
    chk("redir_bubble", {31'h0, if_id_valid}, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_target_pc", if_id_pc, 32'h20);
    chk("redir_target_instr", if_id_instr, rom_mem[8]);

    // stall three cycles at pc=12, then release
    cycle(1'b1, 1'b0, 1'b1, 32'hC);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_pc", pc, 32'hC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_release_pc", if_id_pc, 32'hC);

    // stall and redirect on the same edge
    cycle(1'b1, 1'b1, 1'b1, 32'h8);
    chk("stall_redir_pc", pc, 32'h8);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // redirect outside the ROM window, then fetch
    cycle(1'b1, 1'b0, 1'b1, 32'h100);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("window_fault", {31'h0, fetch_fault}, {31'h0, RC});
    chk("window_instr", if_id_instr, RC ? 32'h0 : rom_mem[0]);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // misaligned redirect, then PC wrap at the top of the address space
    cycle(1'b1, 1'b0, 1'b1, 32'h22);
    chk("misaligned_pc", pc, 32'h20);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // reset while stalled at pc=0x30
    cycle(1'b1, 1'b0, 1'b1, 32'h30);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h40);
    chk("reset_stall_pc", pc, 32'h0);
    chk("reset_stall_count", fetch_count, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0: rp = $urandom_range(0, 255);
        1: rp = $urandom_range(0, 63) * 4;
        2: rp = $urandom;
        default: rp = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      endcase
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 6) == 0),
            rp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
